// File: rtl/rr_mux_reg_if.sv
// Handshake bundle for rr_mux_reg: per-channel producer side plus the
// single registered consumer side and the arbitration mode select.
interface rr_mux_reg_if #(
    parameter int WIDTH     = 5,
    parameter int CHANNELS  = 4,
    parameter int SEL_WIDTH = 2
);
    logic                      mode;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_WIDTH-1:0]      out_sel;
    logic                      out_ready;

    // Producers and consumer together form the environment around the mux.
    modport master (
        output mode,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );

    // The mux itself.
    modport slave (
        input  mode,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel
    );
endinterface

// File: rtl/rr_mux_reg.sv
// Round-robin / fixed-priority N:1 mux with a single registered output
// stage. The winning word is captured together with its channel index,
// and a drain and a reload can happen on the same edge for full throughput.
module rr_mux_reg #(
    parameter int WIDTH     = 5,
    parameter int CHANNELS  = 4,
    parameter int SEL_WIDTH = 2
) (
    input logic          clock,
    input logic          reset,
    rr_mux_reg_if.slave  bus
);

    logic [SEL_WIDTH-1:0] ptr;
    logic [SEL_WIDTH-1:0] start_idx;
    logic [SEL_WIDTH-1:0] grant_idx;
    logic                 grant_found;
    logic                 load_en;
    logic                 transfer;
    logic [WIDTH-1:0]     words [CHANNELS];

    // Split the flat data bus into one word per channel.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            words[c] = bus.in_data[c*WIDTH +: WIDTH];
        end
    end

    // Pick the first requesting channel, searching upward from the pointer
    // (round-robin) or from channel 0 (fixed priority), wrapping around.
    always_comb begin
        logic [SEL_WIDTH-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        start_idx   = bus.mode ? '0 : ptr;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = SEL_WIDTH'((int'(start_idx) + k) % CHANNELS);
            if (!grant_found && bus.in_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // Accept only when the output register is free or being emptied now;
    // holding reset low suppresses every grant.
    always_comb begin
        load_en  = reset & (!bus.out_valid | bus.out_ready);
        transfer = load_en & grant_found;
        bus.in_ready = '0;
        if (transfer) begin
            bus.in_ready[grant_idx] = 1'b1;
        end
    end

    // Output stage: load the granted word, or drop valid once drained.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
        end else if (transfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= words[grant_idx];
            bus.out_sel   <= grant_idx;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the last winner; fixed mode freezes it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (transfer && !bus.mode) begin
            ptr <= (grant_idx == SEL_WIDTH'(CHANNELS-1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg (WIDTH=5, CHANNELS=4): reset, single
// source, round-robin order, fixed priority, backpressure, wrap and drain.
module tb_rr_mux_reg;

    localparam int WIDTH     = 5;
    localparam int CHANNELS  = 4;
    localparam int SEL_WIDTH = 2;

    // Fixed channel words: ch0=11, ch1=06, ch2=15, ch3=0A.
    localparam logic [CHANNELS*WIDTH-1:0] CH_DATA = {5'h0A, 5'h15, 5'h06, 5'h11};

    logic clock;
    logic reset;
    int   checkCount;
    int   errorCount;

    rr_mux_reg_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_WIDTH(SEL_WIDTH)) bus ();

    rr_mux_reg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_WIDTH(SEL_WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive the producer/consumer controls.
    task automatic applyStimulus(input logic mode, input logic [3:0] valid, input logic ready);
        bus.mode      = mode;
        bus.in_valid  = valid;
        bus.in_data   = CH_DATA;
        bus.out_ready = ready;
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle;
        @(posedge clock);
        #1;
    endtask

    // Check the registered output triple.
    task automatic checkWord(input string tag, input logic valid, input logic [4:0] data, input logic [1:0] sel);
        checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'(valid));
        checkOutput({tag, ".data"},  32'(bus.out_data),  32'(data));
        checkOutput({tag, ".sel"},   32'(bus.out_sel),   32'(sel));
    endtask

    logic [4:0] chWord [4];

    initial begin
        checkCount = 0;
        errorCount = 0;
        chWord[0] = 5'h11;
        chWord[1] = 5'h06;
        chWord[2] = 5'h15;
        chWord[3] = 5'h0A;

        // Hold reset with every channel requesting: nothing may be granted.
        reset = 1'b0;
        applyStimulus(1'b0, 4'b1111, 1'b1);
        stepCycle();
        stepCycle();
        checkWord("reset", 1'b0, 5'h00, 2'd0);
        checkOutput("reset.in_ready", 32'(bus.in_ready), 32'h0);

        // Release reset between edges and load one word.
        #3 reset = 1'b1;
        #1;
        checkOutput("first.in_ready", 32'(bus.in_ready), 32'b0001);
        stepCycle();
        checkWord("first", 1'b1, 5'h11, 2'd0);
        checkOutput("first.next_ready", 32'(bus.in_ready), 32'b0010);

        // Asynchronous reset mid-cycle clears the stage at once.
        #2 reset = 1'b0;
        #1;
        checkWord("async_reset", 1'b0, 5'h00, 2'd0);
        checkOutput("async_reset.in_ready", 32'(bus.in_ready), 32'h0);
        #2 reset = 1'b1;
        #1;
        checkOutput("post_reset.in_ready", 32'(bus.in_ready), 32'b0001);

        // Round-robin with all channels requesting: 0,1,2,3,0,1 back to back.
        for (int n = 0; n < 6; n++) begin
            stepCycle();
            checkWord($sformatf("rr%0d", n), 1'b1, chWord[n % 4], 2'(n % 4));
        end

        // Single source on ch2 (ptr is now 2).
        applyStimulus(1'b0, 4'b0100, 1'b1);
        #1;
        checkOutput("single.in_ready", 32'(bus.in_ready), 32'b0100);
        stepCycle();
        checkWord("single", 1'b1, 5'h15, 2'd2);

        // Wrap and skip: ptr=3, channels 3 and 0 requesting.
        applyStimulus(1'b0, 4'b1001, 1'b1);
        #1;
        checkOutput("wrap.in_ready", 32'(bus.in_ready), 32'b1000);
        stepCycle();
        checkWord("wrap3", 1'b1, 5'h0A, 2'd3);
        checkOutput("wrap.in_ready0", 32'(bus.in_ready), 32'b0001);
        stepCycle();
        checkWord("wrap0", 1'b1, 5'h11, 2'd0);

        // No requests: output drains one cycle after the last load.
        applyStimulus(1'b0, 4'b0000, 1'b1);
        #1;
        checkOutput("idle.in_ready", 32'(bus.in_ready), 32'h0);
        stepCycle();
        checkWord("drain", 1'b0, 5'h11, 2'd0);
        stepCycle();
        checkWord("drain_hold", 1'b0, 5'h11, 2'd0);

        // Fixed priority ignores ptr (ptr=1): ch0 wins repeatedly.
        applyStimulus(1'b1, 4'b1111, 1'b1);
        #1;
        checkOutput("fixed.in_ready", 32'(bus.in_ready), 32'b0001);
        for (int n = 0; n < 3; n++) begin
            stepCycle();
            checkWord($sformatf("fixed%0d", n), 1'b1, 5'h11, 2'd0);
        end
        applyStimulus(1'b1, 4'b1110, 1'b1);
        stepCycle();
        checkWord("fixed_drop0", 1'b1, 5'h06, 2'd1);

        // Back to round-robin: resumes from the held ptr of 1.
        applyStimulus(1'b0, 4'b1111, 1'b1);
        #1;
        checkOutput("resume.in_ready", 32'(bus.in_ready), 32'b0010);
        stepCycle();
        checkWord("resume", 1'b1, 5'h06, 2'd1);

        // Load ch3 so the stage holds 0A (ptr wraps to 0).
        applyStimulus(1'b0, 4'b1000, 1'b1);
        stepCycle();
        checkWord("bp_load", 1'b1, 5'h0A, 2'd3);

        // Backpressure for three cycles: no grants, word stable.
        applyStimulus(1'b0, 4'b1111, 1'b0);
        for (int n = 0; n < 3; n++) begin
            #1;
            checkOutput($sformatf("bp%0d.in_ready", n), 32'(bus.in_ready), 32'h0);
            stepCycle();
            checkWord($sformatf("bp%0d", n), 1'b1, 5'h0A, 2'd3);
        end

        // Release: drain and load on the same edge.
        bus.out_ready = 1'b1;
        #1;
        checkOutput("release.in_ready", 32'(bus.in_ready), 32'b0001);
        stepCycle();
        checkWord("release", 1'b1, 5'h11, 2'd0);

        applyStimulus(1'b0, 4'b0000, 1'b1);
        stepCycle();
        checkWord("final_drain", 1'b0, 5'h11, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
